// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned MAX_BURST_DEFAULT = 4;
    localparam int unsigned DW                = 32;
    localparam int unsigned WEW               = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the master not granted last wins.
module dmem_arbiter_rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_gnt_i,
    output logic pick0_o,
    output logic pick1_o
);

    // last_gnt_i = 1 means master 1 was granted most recently
    assign pick0_o = req0_i & (~req1_i | last_gnt_i);
    assign pick1_o = req1_i & (~req0_i | ~last_gnt_i);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter with lockable ownership and burst limiting.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT,
    parameter int unsigned AW        = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           m0_req,
    input  logic [AW-1:0]  m0_addr,
    input  logic [DW-1:0]  m0_wdata,
    input  logic [WEW-1:0] m0_we,
    input  logic           m0_lock,
    output logic           m0_gnt,
    output logic           m0_rvalid,
    output logic [DW-1:0]  m0_rdata,
    input  logic           m1_req,
    input  logic [AW-1:0]  m1_addr,
    input  logic [DW-1:0]  m1_wdata,
    input  logic [WEW-1:0] m1_we,
    input  logic           m1_lock,
    output logic           m1_gnt,
    output logic           m1_rvalid,
    output logic [DW-1:0]  m1_rdata,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    output logic [WEW-1:0] mem_we,
    input  logic [DW-1:0]  mem_rdata
);

    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    arb_state_e    state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    logic          pick0, pick1;
    logic          gnt0_raw, gnt1_raw;
    logic          burst_full;
    logic [CW-1:0] burst_inc;

    dmem_arbiter_rr_pick2 u_pick (
        .req0_i     (m0_req),
        .req1_i     (m1_req),
        .last_gnt_i (last_gnt_q),
        .pick0_o    (pick0),
        .pick1_o    (pick1)
    );

    assign burst_full = (burst_cnt_q >= CW'(MAX_BURST));
    assign burst_inc  = burst_full ? burst_cnt_q : burst_cnt_q + CW'(1);

    // Grant selection: owner keeps the port until it drops req or its burst expires
    always_comb begin
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        unique case (state_q)
            ST_OWN0: begin
                if (m0_req) begin
                    if (burst_full && m1_req) gnt1_raw = 1'b1;
                    else                      gnt0_raw = 1'b1;
                end else begin
                    gnt0_raw = pick0;
                    gnt1_raw = pick1;
                end
            end
            ST_OWN1: begin
                if (m1_req) begin
                    if (burst_full && m0_req) gnt0_raw = 1'b1;
                    else                      gnt1_raw = 1'b1;
                end else begin
                    gnt0_raw = pick0;
                    gnt1_raw = pick1;
                end
            end
            default: begin
                gnt0_raw = pick0;
                gnt1_raw = pick1;
            end
        endcase
    end

    // Next state: burst_cnt includes the grant that entered ownership
    always_comb begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
        last_gnt_d  = last_gnt_q;
        rvalid0_d   = gnt0_raw && (m0_we == '0);
        rvalid1_d   = gnt1_raw && (m1_we == '0);
        if (gnt0_raw) begin
            last_gnt_d = 1'b0;
            if (m0_lock) begin
                state_d     = ST_OWN0;
                burst_cnt_d = (state_q == ST_OWN0) ? burst_inc : CW'(1);
            end
        end else if (gnt1_raw) begin
            last_gnt_d = 1'b1;
            if (m1_lock) begin
                state_d     = ST_OWN1;
                burst_cnt_d = (state_q == ST_OWN1) ? burst_inc : CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    // Grants are forced off while reset is held, even mid-burst
    assign m0_gnt    = gnt0_raw & reset;
    assign m1_gnt    = gnt1_raw & reset;

    assign mem_addr  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : '0);
    assign mem_wdata = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : '0);
    assign mem_we    = m0_gnt ? m0_we    : (m1_gnt ? m1_we    : '0);

    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = rvalid0_q ? mem_rdata : '0;
    assign m1_rdata  = rvalid1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with hand-computed expectations.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_lock, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_we;
    logic        m1_req, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(4), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0; m0_lock = 0;
        m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0; m1_lock = 0;
        mem_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic chk_gnt(input string tag, input logic e0, input logic e1);
        chk({tag, "_g0"}, 32'(m0_gnt), 32'(e0));
        chk({tag, "_g1"}, 32'(m1_gnt), 32'(e1));
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        #2;
        chk("rst_g0", 32'(m0_gnt), 0);
        chk("rst_g1", 32'(m1_gnt), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rv0", 32'(m0_rvalid), 0);
        chk("rst_rd1", m1_rdata, 0);

        // single m0 read with data returned next cycle
        do_reset();
        m0_req = 1; m0_addr = 32'h10;
        #1;
        chk_gnt("rd", 1, 0);
        chk("rd_addr", mem_addr, 32'h10);
        chk("rd_we", 32'(mem_we), 0);
        step();
        m0_req = 0; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_rv0", 32'(m0_rvalid), 1);
        chk("rd_rd0", m0_rdata, 32'hDEADBEEF);
        chk("rd_rv1", 32'(m1_rvalid), 0);
        chk("rd_rd1", m1_rdata, 0);
        chk("rd_idle_addr", mem_addr, 0);
        step();
        #1;
        chk("rd_rv0_off", 32'(m0_rvalid), 0);
        chk("rd_rd0_off", m0_rdata, 0);

        // both requesting without lock alternate starting with m0
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_gnt("alt", (i % 2) == 0, (i % 2) == 1);
            chk("alt_addr", mem_addr, (i % 2) == 0 ? 32'h100 : 32'h200);
            if (i > 0) chk("alt_rv", {30'd0, m1_rvalid, m0_rvalid}, (i % 2) == 1 ? 32'd1 : 32'd2);
            step();
        end

        // m1 locked burst is cut after four grants while m0 waits
        do_reset();
        m1_req = 1; m1_lock = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_gnt("burst", i == 4, i < 4);
            step();
            m0_req = 1;
        end
        m0_req = 0; m1_req = 0; m1_lock = 0;

        // m0 saturates its burst counter, m1 still revokes immediately on arrival
        do_reset();
        m0_req = 1; m0_lock = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_gnt("sat", 1, 0);
            step();
        end
        m1_req = 1;
        #1;
        chk_gnt("sat_revoke", 0, 1);
        step();

        // m0 write and m1 read contend
        do_reset();
        m0_req = 1; m0_we = 4'hF; m0_wdata = 32'h12345678; m0_addr = 32'h20;
        m1_req = 1; m1_addr = 32'h40;
        #1;
        chk_gnt("wr", 1, 0);
        chk("wr_we", 32'(mem_we), 32'hF);
        chk("wr_wdata", mem_wdata, 32'h12345678);
        step();
        m0_req = 0;
        #1;
        chk_gnt("wr_m1", 0, 1);
        chk("wr_m1_we", 32'(mem_we), 0);
        chk("wr_m1_addr", mem_addr, 32'h40);
        chk("wr_no_rv0", 32'(m0_rvalid), 0);
        step();
        m1_req = 0;
        #1;
        chk("wr_rv1", 32'(m1_rvalid), 1);

        // reset asserted mid m1 burst
        do_reset();
        m1_req = 1; m1_lock = 1;
        step();
        step();
        m1_we = 4'hF;
        #1;
        chk_gnt("mid", 0, 1);
        chk("mid_we", 32'(mem_we), 32'hF);
        chk("mid_rv1", 32'(m1_rvalid), 1);
        #1 reset = 1'b0;
        #1;
        chk_gnt("mid_rst", 0, 0);
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_rv1", 32'(m1_rvalid), 0);
        step();
        step();
        reset = 1'b1;
        m1_we = 0; m1_lock = 0; m0_req = 1;
        #1;
        chk_gnt("post_rst", 1, 0);
        chk("post_rst_rv1", 32'(m1_rvalid), 0);
        step();
        m0_req = 0; m1_req = 0;
        #1;
        chk("post_rst_rv1b", 32'(m1_rvalid), 0);

        // locked m0 drops req while m1 waits
        do_reset();
        m0_req = 1; m0_lock = 1;
        #1;
        chk_gnt("drop0", 1, 0);
        step();
        m1_req = 1;
        #1;
        chk_gnt("drop1", 1, 0);
        step();
        m0_req = 0;
        #1;
        chk_gnt("drop2", 0, 1);
        step();
        clear_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // exclusive-grant guard across the whole run
    always @(negedge clk) begin
        if (m0_gnt && m1_gnt) begin
            n_checks++;
            n_errors++;
            $display("FAIL excl: both grants high at t=%0t", $time);
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive grants to one master while the other is requesting.
REQ-002 Parameter: AW, default 32, address width.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m0_req  input  1  master 0 (CPU) access request, level, held until granted.
REQ-006 m0_addr  input  AW  master 0 byte address.
REQ-007 m0_wdata  input  32  master 0 pre-aligned write data.
REQ-008 m0_we  input  4  master 0 byte-lane write mask; 0 means read.
REQ-009 m0_lock  input  1  master 0 requests ownership retention after this grant.
REQ-010 m0_gnt  output  1  master 0 access accepted this cycle.
REQ-011 m0_rvalid  output  1  master 0 read data valid.
REQ-012 m0_rdata  output  32  master 0 read data.
REQ-013 m1_req, m1_addr, m1_wdata, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_rdata: identical to the m0_* ports, for master 1 (DMA/debug).
REQ-014 mem_addr  output  AW  dmem address.
REQ-015 mem_wdata  output  32  dmem write data.
REQ-016 mem_we  output  4  dmem byte write enables.
REQ-017 mem_rdata  input  32  dmem read data, valid one cycle after the address.

Function
REQ-018 Grant is combinational from req and state; at most one of m0_gnt/m1_gnt is high per cycle; one access is issued per granted cycle.
REQ-019 In the grant cycle: mem_addr/mem_wdata = granted master's values; mem_we = granted master's we; mem_we = 0 when there is no grant.
REQ-020 With no grant: mem_addr = 0, mem_wdata = 0.
REQ-021 Read (we==0) granted in cycle N: that master's rvalid = 1 in cycle N+1, rdata = mem_rdata in N+1; rvalid low otherwise; rdata of a master whose rvalid is low = 0.
REQ-022 Writes produce no rvalid.
REQ-023 FSM states:
- IDLE: no owner.
- OWN0: master 0 owns.
- OWN1: master 1 owns.
REQ-024 IDLE arbitration:
- Single requester wins.
- Both requesting: the master not granted last (last_gnt register) wins.
REQ-025 On a grant with that master's lock = 1, next state = OWN<master>; lock = 0 gives next state IDLE.
REQ-026 OWNx, own req high: grant x, irrespective of the other master, unless REQ-027 applies.
REQ-027 burst_cnt counts consecutive grants in OWNx and resets on entry.
- burst_cnt reaches MAX_BURST while the other master requests: ownership is revoked, the other master is granted in that same cycle, and the FSM enters IDLE or OWN<other> according to that master's lock.
REQ-028 OWNx, own req low: return to IDLE, other master arbitrated that same cycle per REQ-024.
REQ-029 OWNx, own lock low at a grant: next state IDLE.
REQ-030 last_gnt updates on every grant.
REQ-031 burst_cnt saturates at MAX_BURST; its width is clog2(MAX_BURST)+1.

Reset
REQ-032 reset low, asynchronously:
- FSM = IDLE, last_gnt = 1 (master 0 wins the first tie), burst_cnt = 0.
- m*_rvalid = 0, m*_rdata = 0.
- m*_gnt = 0 and mem_we = 0 while reset is low, including mid-burst.
REQ-033 A read granted in the cycle reset asserts produces no rvalid after reset release.

Structure
REQ-034 State encoding (IDLE/OWN0/OWN1) and the MAX_BURST default live in the shared cpu package.
REQ-035 One sub-module is natural: rr_pick2 (2-way round-robin pick from req pair and last_gnt); the remainder is flat.

Verification
REQ-036 m0 read at 0x10 alone, mem returns 0xDEADBEEF -> m0_gnt in cycle N, m0_rvalid and m0_rdata=0xDEADBEEF in N+1, m1_rvalid=0.
REQ-037 Both req from reset, lock=0 -> grants alternate m0,m1,m0,m1.
REQ-038 m1 lock=1 and req held, m0 req continuous -> 4 m1 grants, then m0 granted the following cycle; no cycle has two grants.
REQ-039 m0 SW 0x12345678 mask 1111 concurrent with m1 read -> m0 write issued first with mem_we=1111, m1 granted next cycle, mem_we=0000 on the m1 read.
REQ-040 reset low mid-OWN1 burst -> gnt/mem_we/rvalid all 0 immediately; after release with both req, m0 granted first.
REQ-041 m0 lock=1 then drops req with m1 requesting -> m1 granted in the same cycle m0_req falls.
